// File: rtl/alu_issue_seq.sv
// Issue stage feeding the 8-bit shifter/ALU: holds an 8x8 register file, accepts one
// instruction per three cycles, drives registered operands and writes the result back.
module alu_issue_seq #(
    parameter int NREG = 8,
    parameter int W    = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         instr_valid,
    input  logic [16:0]  instr,
    output logic         instr_ready,
    input  logic         wr_en,
    input  logic [2:0]   wr_addr,
    input  logic [W-1:0] wr_data,
    input  logic [2:0]   rd_addr,
    output logic [W-1:0] rd_data,
    output logic [W-1:0] inp1,
    output logic [W-1:0] inp2,
    output logic [2:0]   shiftImm,
    output logic         selShiftAmt,
    output logic [2:0]   oper,
    output logic         selOut,
    input  logic [W-1:0] alu_out,
    output logic [W-1:0] result,
    output logic         result_valid,
    output logic         zero,
    output logic         busy
);

    typedef enum logic [1:0] {IDLE, ISSUE, DONE} state_t;

    state_t       state;
    logic [W-1:0] rf [NREG];
    logic [2:0]   rd_q;
    logic         accept;

    logic [2:0] f_oper, f_rd, f_rs1, f_rs2, f_imm;
    logic       f_sel_out, f_sel_amt;

    assign f_oper    = instr[16:14];
    assign f_sel_out = instr[13];
    assign f_sel_amt = instr[12];
    assign f_rd      = instr[11:9];
    assign f_rs1     = instr[8:6];
    assign f_rs2     = instr[5:3];
    assign f_imm     = instr[2:0];

    assign accept  = instr_valid && instr_ready;
    assign rd_data = rf[rd_addr];

    // NOTE: all state below uses non-blocking assignments so every register samples
    // pre-edge values; this is what lets an instruction read rf contents before a write.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            instr_ready  <= 1'b1;
            busy         <= 1'b0;
            result_valid <= 1'b0;
            zero         <= 1'b1;
            result       <= '0;
            inp1         <= '0;
            inp2         <= '0;
            oper         <= '0;
            shiftImm     <= '0;
            selOut       <= 1'b0;
            selShiftAmt  <= 1'b0;
            rd_q         <= '0;
            // NOTE: the register file is cleared here on purpose, so it must stay in
            // flops; a RAM macro could not honour this reset.
            for (int i = 0; i < NREG; i++) begin
                rf[i] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        inp1        <= rf[f_rs1];
                        inp2        <= rf[f_rs2];
                        oper        <= f_oper;
                        selOut      <= f_sel_out;
                        selShiftAmt <= f_sel_amt;
                        shiftImm    <= f_imm;
                        rd_q        <= f_rd;
                        instr_ready <= 1'b0;
                        busy        <= 1'b1;
                        state       <= ISSUE;
                    end else if (wr_en) begin
                        rf[wr_addr] <= wr_data;
                    end
                end
                ISSUE: begin
                    result       <= alu_out;
                    rf[rd_q]     <= alu_out;
                    zero         <= (alu_out == '0);
                    result_valid <= 1'b1;
                    state        <= DONE;
                end
                DONE: begin
                    result_valid <= 1'b0;
                    instr_ready  <= 1'b1;
                    busy         <= 1'b0;
                    state        <= IDLE;
                end
                default: begin
                    state        <= IDLE;
                    instr_ready  <= 1'b1;
                    busy         <= 1'b0;
                    result_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_issue_seq.sv
// Self-checking bench for alu_issue_seq: a behavioural shifter/ALU drives alu_out, and an
// array-based register-file model predicts results, timing and write-back effects.
module tb_alu_issue_seq;

    logic        clk = 1'b0;
    logic        reset, instr_valid, wr_en;
    logic [16:0] instr;
    logic [2:0]  wr_addr, rd_addr;
    logic [7:0]  wr_data, rd_data, inp1, inp2, alu_out, result;
    logic [2:0]  shiftImm, oper;
    logic        instr_ready, selShiftAmt, selOut, result_valid, zero, busy;

    int checks = 0;
    int errors = 0;
    logic [7:0] ref_rf [8];

    always #5 clk = ~clk;

    alu_issue_seq dut (
        .clk(clk), .reset(reset), .instr_valid(instr_valid), .instr(instr),
        .instr_ready(instr_ready), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_addr(rd_addr), .rd_data(rd_data), .inp1(inp1), .inp2(inp2),
        .shiftImm(shiftImm), .selShiftAmt(selShiftAmt), .oper(oper), .selOut(selOut),
        .alu_out(alu_out), .result(result), .result_valid(result_valid), .zero(zero),
        .busy(busy)
    );

    // Stand-in for shifterAndALU: ALU ops 0..7 = pass,add,sub,and,or,not,xor,passB;
    // shifter ops 0..7 = pass,srl,rol,sra,sll,ror,pass,pass.
    function automatic logic [7:0] shalu(input logic [7:0] a, input logic [7:0] b,
                                         input logic [2:0] op, input logic sel_out,
                                         input logic sel_amt, input logic [2:0] imm);
        logic [2:0]  amt;
        logic [15:0] dbl;
        logic [7:0]  r;
        amt = sel_amt ? imm : b[2:0];
        r = a;
        if (sel_out) begin
            case (op)
                3'd1: r = a >> amt;
                3'd2: begin dbl = {a, a} << amt; r = dbl[15:8]; end
                3'd3: r = $unsigned($signed(a) >>> amt);
                3'd4: r = a << amt;
                3'd5: begin dbl = {a, a} >> amt; r = dbl[7:0]; end
                default: r = a;
            endcase
        end else begin
            case (op)
                3'd1: r = a + b;
                3'd2: r = a - b;
                3'd3: r = a & b;
                3'd4: r = a | b;
                3'd5: r = ~a;
                3'd6: r = a ^ b;
                3'd7: r = b;
                default: r = a;
            endcase
        end
        return r;
    endfunction

    always_comb alu_out = shalu(inp1, inp2, oper, selOut, selShiftAmt, shiftImm);

    function automatic logic [16:0] enc(input int op, input int so, input int ssa, input int rd,
                                        input int rs1, input int rs2, input int imm);
        return {3'(op), 1'(so), 1'(ssa), 3'(rd), 3'(rs1), 3'(rs2), 3'(imm)};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input logic [2:0] addr, input logic [7:0] data);
        wr_en = 1'b1; wr_addr = addr; wr_data = data;
        step();
        wr_en = 1'b0;
        ref_rf[addr] = data;
        rd_addr = addr;
        #1;
        checks++;
        if (rd_data !== data) begin
            errors++; $display("FAIL preload r%0d: got %0d expected %0d", addr, rd_data, data);
        end
    endtask

    task automatic check_rf(input string name);
        for (int i = 0; i < 8; i++) begin
            rd_addr = 3'(i);
            #1;
            checks++;
            if (rd_data !== ref_rf[i]) begin
                errors++;
                $display("FAIL %s rf[%0d]: got %0d expected %0d", name, i, rd_data, ref_rf[i]);
            end
        end
    endtask

    // Issues one instruction from IDLE and checks the whole 3-cycle transaction.
    task automatic issue(input logic [16:0] ins, input logic wr_acc, input logic wr_busy,
                         input string name);
        logic [2:0] op, rd, rs1, rs2, imm;
        logic       so, ssa;
        logic [7:0] a, b, expv;
        {op, so, ssa, rd, rs1, rs2, imm} = ins;
        a = ref_rf[rs1];
        b = ref_rf[rs2];
        expv = shalu(a, b, op, so, ssa, imm);
        checks++;
        if (instr_ready !== 1'b1) begin
            errors++; $display("FAIL %s ready_before: got %b expected 1", name, instr_ready);
        end
        instr = ins; instr_valid = 1'b1;
        if (wr_acc) begin
            wr_en = 1'b1; wr_addr = 3'($urandom); wr_data = 8'($urandom);
        end
        step();
        instr_valid = 1'b0; instr = 17'($urandom);
        wr_en = wr_busy; wr_addr = 3'($urandom); wr_data = 8'($urandom);
        checks++;
        if ({instr_ready, busy, result_valid} !== 3'b010) begin
            errors++;
            $display("FAIL %s issue_flags: got ready/busy/valid=%b expected 010", name,
                     {instr_ready, busy, result_valid});
        end
        checks++;
        if ({inp1, inp2, oper, selOut, selShiftAmt, shiftImm} !== {a, b, op, so, ssa, imm}) begin
            errors++;
            $display("FAIL %s operands: got inp1=%0d inp2=%0d oper=%0d sel=%b%b imm=%0d expected %0d %0d %0d %b%b %0d",
                     name, inp1, inp2, oper, selOut, selShiftAmt, shiftImm, a, b, op, so, ssa, imm);
        end
        step();
        ref_rf[rd] = expv;
        checks++;
        if ({result_valid, instr_ready, result, zero} !== {1'b1, 1'b0, expv, expv == 8'd0}) begin
            errors++;
            $display("FAIL %s result: got valid=%b ready=%b result=%0d zero=%b expected 1 0 %0d %b",
                     name, result_valid, instr_ready, result, zero, expv, expv == 8'd0);
        end
        rd_addr = rd;
        #1;
        checks++;
        if (rd_data !== expv) begin
            errors++; $display("FAIL %s writeback r%0d: got %0d expected %0d", name, rd, rd_data, expv);
        end
        step();
        wr_en = 1'b0;
        checks++;
        if ({result_valid, instr_ready, busy, result} !== {1'b0, 1'b1, 1'b0, expv}) begin
            errors++;
            $display("FAIL %s done: got valid=%b ready=%b busy=%b result=%0d expected 0 1 0 %0d",
                     name, result_valid, instr_ready, busy, result, expv);
        end
    endtask

    task automatic test_reset();
        checks++;
        if ({instr_ready, busy, result_valid, zero} !== 4'b1001) begin
            errors++;
            $display("FAIL reset_flags: got ready/busy/valid/zero=%b expected 1001",
                     {instr_ready, busy, result_valid, zero});
        end
        checks++;
        if ({result, inp1, inp2, oper, shiftImm, selOut, selShiftAmt} !== 32'd0) begin
            errors++;
            $display("FAIL reset_outputs: got result=%0d inp1=%0d inp2=%0d oper=%0d imm=%0d sel=%b%b expected all 0",
                     result, inp1, inp2, oper, shiftImm, selOut, selShiftAmt);
        end
        check_rf("reset");
    endtask

    task automatic test_basic();
        preload(3'd1, 8'd80);
        preload(3'd2, 8'd20);
        issue(enc(1, 0, 0, 3, 1, 2, 0), 1'b0, 1'b0, "add");
    endtask

    task automatic test_back_to_back();
        logic [16:0] prog [3];
        logic [7:0]  exp_q [$];
        int          acc_cyc [$];
        int          n = 0;
        int          pulses = 0;
        logic [2:0]  op, rd, rs1, rs2, imm;
        logic        so, ssa;
        prog[0] = enc(2, 0, 0, 4, 1, 2, 0);
        prog[1] = enc(3, 0, 0, 5, 1, 2, 0);
        prog[2] = enc(5, 0, 0, 6, 1, 2, 0);
        instr_valid = 1'b1;
        for (int c = 0; c < 12; c++) begin
            if (result_valid) begin
                pulses++;
                checks++;
                if (exp_q.size() == 0 || result !== exp_q[0]) begin
                    errors++; $display("FAIL b2b result: got %0d at cycle %0d", result, c);
                end
                if (exp_q.size() != 0) void'(exp_q.pop_front());
            end
            if (instr_ready && n < 3) begin
                acc_cyc.push_back(c);
                instr = prog[n];
                {op, so, ssa, rd, rs1, rs2, imm} = prog[n];
                exp_q.push_back(shalu(ref_rf[rs1], ref_rf[rs2], op, so, ssa, imm));
                ref_rf[rd] = exp_q[exp_q.size() - 1];
                n++;
            end else if (instr_ready) begin
                instr_valid = 1'b0;
            end else begin
                instr = 17'($urandom);
            end
            step();
        end
        instr_valid = 1'b0;
        checks++;
        if (acc_cyc.size() != 3 || acc_cyc[1] - acc_cyc[0] != 3 || acc_cyc[2] - acc_cyc[1] != 3) begin
            errors++; $display("FAIL b2b spacing: got %0d accepts, first at %0d", acc_cyc.size(),
                               acc_cyc.size() ? acc_cyc[0] : -1);
        end
        checks++;
        if (pulses != 3) begin
            errors++; $display("FAIL b2b pulses: got %0d expected 3", pulses);
        end
        check_rf("b2b");
    endtask

    task automatic test_shifter();
        preload(3'd1, 8'd80);
        preload(3'd2, 8'd20);
        issue(enc(1, 1, 1, 3, 1, 2, 2), 1'b0, 1'b0, "srl_imm");
        issue(enc(4, 1, 1, 3, 1, 2, 2), 1'b0, 1'b0, "sll_imm");
        issue(enc(3, 1, 0, 3, 1, 2, 7), 1'b0, 1'b0, "sra_reg");
    endtask

    task automatic test_overflow_zero();
        preload(3'd1, 8'd15);  preload(3'd2, 8'd26);
        issue(enc(2, 0, 0, 0, 1, 2, 0), 1'b0, 1'b1, "sub_wrap");
        preload(3'd1, 8'd150); preload(3'd2, 8'd150);
        issue(enc(1, 0, 0, 0, 1, 2, 0), 1'b0, 1'b1, "add_wrap");
        preload(3'd1, 8'd0);
        issue(enc(5, 0, 0, 7, 1, 2, 0), 1'b0, 1'b0, "not_zero");
        preload(3'd1, 8'h0F); preload(3'd2, 8'hF0);
        issue(enc(3, 0, 0, 7, 1, 2, 0), 1'b0, 1'b0, "and_zero");
    endtask

    task automatic test_hazard();
        preload(3'd1, 8'd80);
        preload(3'd2, 8'd20);
        issue(enc(1, 0, 0, 1, 1, 2, 0), 1'b1, 1'b1, "hazard1");
        issue(enc(1, 0, 0, 1, 1, 2, 0), 1'b1, 1'b0, "hazard2");
        check_rf("hazard");
    endtask

    task automatic test_reset_in_issue();
        preload(3'd4, 8'd33);
        instr = enc(1, 0, 0, 4, 4, 4, 0); instr_valid = 1'b1;
        step();
        instr_valid = 1'b0;
        reset = 1'b1;
        step();
        reset = 1'b0;
        for (int i = 0; i < 8; i++) ref_rf[i] = 8'd0;
        checks++;
        if ({instr_ready, busy, result_valid, zero, result, inp1, inp2} !== {4'b1001, 24'd0}) begin
            errors++;
            $display("FAIL rst_issue: got ready/busy/valid/zero=%b result=%0d inp1=%0d inp2=%0d expected 1001 0 0 0",
                     {instr_ready, busy, result_valid, zero}, result, inp1, inp2);
        end
        step();
        checks++;
        if (result_valid !== 1'b0 || instr_ready !== 1'b1) begin
            errors++; $display("FAIL rst_issue_after: got valid=%b ready=%b expected 0 1",
                               result_valid, instr_ready);
        end
        check_rf("rst_issue");
        issue(enc(5, 0, 0, 2, 0, 0, 0), 1'b0, 1'b0, "post_reset");
    endtask

    task automatic test_random();
        for (int k = 0; k < 24; k++) begin
            if ($urandom_range(2, 0) == 0) preload(3'($urandom), 8'($urandom));
            issue(17'($urandom), 1'($urandom), 1'($urandom), "random");
        end
        check_rf("random");
    endtask

    initial begin
        reset = 1'b1; instr_valid = 1'b0; instr = '0;
        wr_en = 1'b0; wr_addr = '0; wr_data = '0; rd_addr = '0;
        for (int i = 0; i < 8; i++) ref_rf[i] = 8'd0;
        step();
        step();
        reset = 1'b0;
        test_reset();
        test_basic();
        test_back_to_back();
        test_shifter();
        test_overflow_zero();
        test_hazard();
        test_reset_in_issue();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
